// File: rtl/regfile_writeback.sv
// regfile_writeback: single write-port owner merging ALU results and buffered loads,
// with a pending-load scoreboard. Optional macro WB_FWD_EN adds write-cycle forwarding.
`default_nettype none

module regfile_writeback #(
   parameter int FIFO_DEPTH = 4,
   parameter int XLEN       = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alu_valid,
   input  logic [4:0]                    alu_rd,
   input  logic [XLEN-1:0]               alu_data,
   input  logic                          ld_valid,
   output logic                          ld_ready,
   input  logic [4:0]                    ld_rd,
   input  logic [XLEN-1:0]               ld_data,
   input  logic                          mark_valid,
   input  logic [4:0]                    mark_rd,
   input  logic [4:0]                    chk_rs1,
   input  logic [4:0]                    chk_rs2,
   output logic                          busy1,
   output logic                          busy2,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          we,
   output logic [4:0]                    wrAddr,
   output logic [XLEN-1:0]               wrData
`ifdef WB_FWD_EN
   ,
   output logic                          fwd1_valid,
   output logic                          fwd2_valid,
   output logic [XLEN-1:0]               fwd1_data,
   output logic [XLEN-1:0]               fwd2_data
`endif
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   logic [4:0]        r_fifo_rd   [FIFO_DEPTH];
   logic [XLEN-1:0]   r_fifo_data [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_rptr;
   logic [CNT_W-1:0]  r_count;

   logic              r_we;
   logic              r_src_ld;
   logic [4:0]        r_wr_addr;
   logic [XLEN-1:0]   r_wr_data;
   logic [31:0]       r_pending;

   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_alu_sel;
   logic [4:0]        w_head_rd;
   logic [XLEN-1:0]   w_head_data;
   logic [31:0]       w_pending_nxt;

   assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_push      = ld_valid && !w_full;
   assign w_alu_sel   = alu_valid && (alu_rd != 5'd0);
   // ALU with rd=0 is dropped outright so it never steals the slot from the FIFO.
   assign w_pop       = !w_alu_sel && (r_count != '0);
   assign w_head_rd   = r_fifo_rd[r_rptr];
   assign w_head_data = r_fifo_data[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wptr]   <= ld_rd;
         r_fifo_data[r_wptr] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we      <= 1'b0;
         r_src_ld  <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (w_alu_sel) begin
         r_we      <= 1'b1;
         r_src_ld  <= 1'b0;
         r_wr_addr <= alu_rd;
         r_wr_data <= alu_data;
      end else if (w_pop && (w_head_rd != 5'd0)) begin
         r_we      <= 1'b1;
         r_src_ld  <= 1'b1;
         r_wr_addr <= w_head_rd;
         r_wr_data <= w_head_data;
      end else begin
         r_we      <= 1'b0;
         r_src_ld  <= 1'b0;
      end
   end

   // Clear is applied before set so a new mark on the commit edge survives.
   always_comb begin
      w_pending_nxt = r_pending;
      if (r_we && r_src_ld) w_pending_nxt[r_wr_addr] = 1'b0;
      if (mark_valid && (mark_rd != 5'd0)) w_pending_nxt[mark_rd] = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pending <= '0;
      else        r_pending <= w_pending_nxt;
   end

   assign ld_ready   = !w_full;
   assign fifo_count = r_count;
   assign we         = r_we;
   assign wrAddr     = r_wr_addr;
   assign wrData     = r_wr_data;

`ifdef WB_FWD_EN
   assign fwd1_valid = r_we && (r_wr_addr != 5'd0) && (r_wr_addr == chk_rs1);
   assign fwd2_valid = r_we && (r_wr_addr != 5'd0) && (r_wr_addr == chk_rs2);
   assign fwd1_data  = r_wr_data;
   assign fwd2_data  = r_wr_data;
   assign busy1      = r_pending[chk_rs1] && !(fwd1_valid && r_src_ld);
   assign busy2      = r_pending[chk_rs2] && !(fwd2_valid && r_src_ld);
`else
   assign busy1      = r_pending[chk_rs1];
   assign busy2      = r_pending[chk_rs2];
`endif

endmodule

`default_nettype wire
